// File: rtl/dac_sched_pkg.sv
// Shared types and constants for the DAC frame scheduler: FSM states, frame layout
// and the counter-width helper.
package dac_sched_pkg;

    localparam int DATA_W  = 8;
    localparam int FRAME_W = DATA_W + 3;

    typedef enum logic [2:0] {
        IDLE,
        SHIFT,
        LOAD,
        GAP,
        LDAC
    } state_t;

    // Shifted MSB first, so the address leaves the pin before RNG and data.
    typedef struct packed {
        logic [1:0]        addr;
        logic              rng;
        logic [DATA_W-1:0] data;
    } frame_t;

    // Bits needed for a counter running 0..n-1, never less than one.
    function automatic int cnt_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin search: first set request at or after the pointer, wrapping.
// Purely combinational; the pointer register lives in the scheduler.
module rr_arbiter #(
    parameter int N_REQ = 4
) (
    input  logic [N_REQ-1:0] req,
    input  logic [1:0]       ptr,
    output logic [N_REQ-1:0] grant,
    output logic [1:0]       idx
);

    logic found;

    always_comb begin
        grant = '0;
        idx   = '0;
        found = 1'b0;
        for (int k = 0; k < N_REQ; k++) begin
            for (int i = 0; i < N_REQ; i++) begin
                if (!found && req[i] && (i == (int'(ptr) + k) % N_REQ)) begin
                    found    = 1'b1;
                    grant[i] = 1'b1;
                    idx      = 2'(i);
                end
            end
        end
    end

endmodule

// File: rtl/dac_frame_scheduler.sv
// Arbitrates up to four producers onto one serial DAC and sequences each frame.
// Build option DAC_LDAC_SYNC_EN: pulse LDAC once the request queue drains.
module dac_frame_scheduler
    import dac_sched_pkg::*;
#(
    parameter int N_REQ        = 4,
    parameter int CLK_DIV      = 4,
    parameter int LOAD_LOW_CYC = 2,
    parameter bit RNG_BIT      = 1'b0
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [N_REQ-1:0]        req,
    input  logic [N_REQ*DATA_W-1:0] req_data,
    output logic [N_REQ-1:0]        ack,
    output logic                    busy,
    output logic                    dac_clk,
    output logic                    dac_data,
    output logic                    dac_load,
    output logic                    dac_ldac,
    output state_t                  fsm_state
);

    localparam int              PH_W     = cnt_width(2 * CLK_DIV);
    localparam int              LD_W     = cnt_width(LOAD_LOW_CYC);
    localparam logic [PH_W-1:0] PH_HALF  = PH_W'(CLK_DIV);
    localparam logic [PH_W-1:0] PH_LAST  = PH_W'(2 * CLK_DIV - 1);
    localparam logic [LD_W-1:0] LD_LAST  = LD_W'(LOAD_LOW_CYC - 1);
    localparam logic [3:0]      BIT_LAST = 4'(FRAME_W - 1);
    localparam logic [1:0]      PTR_LAST = 2'(N_REQ - 1);

    state_t            state, state_n;
    logic [PH_W-1:0]   phase, phase_n;
    logic [3:0]        bit_cnt, bit_n;
    logic [LD_W-1:0]   ld_cnt, ld_n;
    frame_t            shreg, shreg_n, frame_in;
    logic [1:0]        ptr, ptr_n, gidx;
    logic [N_REQ-1:0]  ack_n, grant;

    rr_arbiter #(.N_REQ(N_REQ)) u_arb (
        .req   (req),
        .ptr   (ptr),
        .grant (grant),
        .idx   (gidx)
    );

    always_comb begin
        frame_in.addr = gidx;
        frame_in.rng  = RNG_BIT;
        frame_in.data = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (gidx == 2'(i)) frame_in.data = req_data[i*DATA_W +: DATA_W];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            phase   <= '0;
            bit_cnt <= '0;
            ld_cnt  <= '0;
            shreg   <= '0;
            ptr     <= '0;
            ack     <= '0;
        end else begin
            state   <= state_n;
            phase   <= phase_n;
            bit_cnt <= bit_n;
            ld_cnt  <= ld_n;
            shreg   <= shreg_n;
            ptr     <= ptr_n;
            ack     <= ack_n;
        end
    end

    // Handshake: req[i] is a level held with stable data until ack[i]; ack is a
    // one-cycle pulse marking the data latched, and a req still high afterwards is a new request.
    always_comb begin
        state_n = state;
        phase_n = phase;
        bit_n   = bit_cnt;
        ld_n    = ld_cnt;
        shreg_n = shreg;
        ptr_n   = ptr;
        ack_n   = '0;
        case (state)
            IDLE: begin
                if (|req) begin
                    ack_n   = grant;
                    shreg_n = frame_in;
                    ptr_n   = (gidx == PTR_LAST) ? 2'd0 : gidx + 2'd1;
                    phase_n = '0;
                    bit_n   = '0;
                    state_n = SHIFT;
                end
            end
            SHIFT: begin
                if (phase == PH_LAST) begin
                    phase_n = '0;
                    shreg_n = frame_t'({shreg[FRAME_W-2:0], 1'b0});
                    if (bit_cnt == BIT_LAST) begin
                        ld_n    = '0;
                        state_n = LOAD;
                    end else begin
                        bit_n = bit_cnt + 4'd1;
                    end
                end else begin
                    phase_n = phase + 1'b1;
                end
            end
            LOAD: begin
                if (ld_cnt == LD_LAST) begin
                    phase_n = '0;
                    state_n = GAP;
                end else begin
                    ld_n = ld_cnt + 1'b1;
                end
            end
            GAP: begin
                if (phase == PH_LAST) begin
`ifdef DAC_LDAC_SYNC_EN
                    // A pending request defers the common update until the queue drains.
                    if (req == '0) begin
                        ld_n    = '0;
                        state_n = LDAC;
                    end else begin
                        state_n = IDLE;
                    end
`else
                    state_n = IDLE;
`endif
                end else begin
                    phase_n = phase + 1'b1;
                end
            end
`ifdef DAC_LDAC_SYNC_EN
            LDAC: begin
                if (ld_cnt == LD_LAST) state_n = IDLE;
                else                   ld_n    = ld_cnt + 1'b1;
            end
`endif
            default: state_n = IDLE;
        endcase
    end

    assign busy      = (state != IDLE);
    assign dac_clk   = (state == SHIFT) && (phase < PH_HALF);
    assign dac_data  = (state == SHIFT) ? shreg[FRAME_W-1] : 1'b0;
    assign dac_load  = (state != LOAD);
    assign fsm_state = state;
`ifdef DAC_LDAC_SYNC_EN
    assign dac_ldac  = (state != LDAC);
`else
    assign dac_ldac  = 1'b0;
`endif

endmodule

// File: tb/tb_dac_frame_scheduler.sv
// Directed bench for dac_frame_scheduler: frames captured off the DAC pins and
// acks are scored against expectations queued when each request is driven.
module tb_dac_frame_scheduler;
    import dac_sched_pkg::*;

    localparam int   N_REQ        = 4;
    localparam int   CLK_DIV      = 4;
    localparam int   LOAD_LOW_CYC = 2;
    localparam logic RNG          = 1'b0;
    localparam int   BIT_CYC      = 2 * CLK_DIV;
    localparam int   LOAD_START   = FRAME_W * BIT_CYC;
    localparam int   FRAME_LEN    = LOAD_START + LOAD_LOW_CYC + BIT_CYC;
`ifdef DAC_LDAC_SYNC_EN
    localparam logic LDAC_IDLE = 1'b1;
    localparam int   LDAC_CYC  = LOAD_LOW_CYC;
`else
    localparam logic LDAC_IDLE = 1'b0;
    localparam int   LDAC_CYC  = 0;
`endif

    logic                    clk;
    logic                    reset;
    logic [N_REQ-1:0]        req;
    logic [N_REQ*DATA_W-1:0] req_data;
    logic [N_REQ-1:0]        ack;
    logic                    busy, dac_clk, dac_data, dac_load, dac_ldac;
    state_t                  fsm_state;

    int n_cmp;
    int n_err;
    logic [FRAME_W-1:0] exp_q[$];
    logic [N_REQ-1:0]   ack_q[$];

    dac_frame_scheduler #(
        .N_REQ(N_REQ), .CLK_DIV(CLK_DIV), .LOAD_LOW_CYC(LOAD_LOW_CYC), .RNG_BIT(RNG)
    ) dut (
        .clk(clk), .reset(reset), .req(req), .req_data(req_data), .ack(ack), .busy(busy),
        .dac_clk(dac_clk), .dac_data(dac_data), .dac_load(dac_load), .dac_ldac(dac_ldac),
        .fsm_state(fsm_state)
    );

    // clock / watchdog
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // scoreboard monitor: pins sampled on the falling clk edge
    logic               prev_dclk = 1'b0;
    logic               prev_load = 1'b1;
    logic [N_REQ-1:0]   prev_ack  = '0;
    logic [FRAME_W-1:0] bits      = '0;
    int                 nbits     = 0;
    int                 ldac_bad  = 0;

    always @(negedge clk) begin
        if (dac_ldac !== LDAC_IDLE && dut.fsm_state != LDAC) ldac_bad++;
        if (!reset) begin
            nbits     = 0;
            bits      = '0;
            prev_dclk = 1'b0;
            prev_load = 1'b1;
            prev_ack  = '0;
        end else begin
            if (prev_dclk && !dac_clk) begin
                bits = {bits[FRAME_W-2:0], dac_data};
                nbits++;
            end
            if (prev_load && !dac_load) begin
                check("frame_pending", 32'(exp_q.size() != 0), 1);
                if (exp_q.size() != 0) check("frame_word", 32'(bits), 32'(exp_q.pop_front()));
                check("frame_bits", nbits, FRAME_W);
                nbits = 0;
            end
            if (ack != '0) begin
                check("ack_after_idle", 32'(prev_ack), 0);
                check("ack_pending", 32'(ack_q.size() != 0), 1);
                if (ack_q.size() != 0) check("ack_onehot", 32'(ack), 32'(ack_q.pop_front()));
            end
            prev_dclk = dac_clk;
            prev_load = dac_load;
            prev_ack  = ack;
        end
    end

    // driver tasks
    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic set_data(input int ch, input logic [DATA_W-1:0] d);
        req_data[ch*DATA_W +: DATA_W] = d;
    endtask

    task automatic push(input int ch, input logic [DATA_W-1:0] d, input bit with_frame);
        ack_q.push_back(N_REQ'(1) << ch);
        if (with_frame) exp_q.push_back({2'(ch), RNG, d});
    endtask

    task automatic wait_ack(input string tag, input int exp_ch);
        int ch;
        ch = -1;
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            if (ack != '0) break;
        end
        for (int i = 0; i < N_REQ; i++) if (ack[i]) ch = i;
        check(tag, ch, exp_ch);
    endtask

    task automatic wait_idle(input string tag);
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            if (!busy) break;
        end
        check(tag, 32'(busy), 0);
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_ack"}, 32'(ack), 0);
        check({tag, "_busy"}, 32'(busy), 0);
        check({tag, "_dac_clk"}, 32'(dac_clk), 0);
        check({tag, "_dac_data"}, 32'(dac_data), 0);
        check({tag, "_dac_load"}, 32'(dac_load), 1);
        check({tag, "_dac_ldac"}, 32'(dac_ldac), 32'(LDAC_IDLE));
        check({tag, "_state"}, 32'(fsm_state), 32'(IDLE));
    endtask

    task automatic apply_reset(input string tag);
        @(negedge clk);
        reset = 1'b0;
        req   = '0;
        tick(3);
        check_idle(tag);
        @(negedge clk);
        reset = 1'b1;
    endtask

    int load_first, load_last, busy_fall, ldac_first, ldac_last, ldac_early;
    logic busy_at_gap_end;

    initial begin
        n_cmp    = 0;
        n_err    = 0;
        reset    = 1'b0;
        req      = '0;
        req_data = '0;
        apply_reset("rst0");

        // single request, full frame timing
        set_data(2, 8'hA5);
        push(2, 8'hA5, 1);
        req = 4'b0100;
        wait_ack("t1_grant", 2);
        req = '0;
        load_first = -1; load_last = -1; busy_fall = -1;
        for (int k = 1; k <= FRAME_LEN + LDAC_CYC + 4; k++) begin
            @(negedge clk);
            if (!dac_load) begin
                if (load_first < 0) load_first = k;
                load_last = k;
            end
            if (!busy && busy_fall < 0) busy_fall = k;
        end
        check("t1_load_first", load_first, LOAD_START);
        check("t1_load_last", load_last, LOAD_START + LOAD_LOW_CYC - 1);
        check("t1_busy_fall", busy_fall, FRAME_LEN + LDAC_CYC);

        // all four held: strict rotation
        apply_reset("rst2");
        for (int i = 0; i < N_REQ; i++) set_data(i, 8'(8'h11 * (i + 1)));
        for (int n = 0; n < 5; n++) push(n % 4, 8'(8'h11 * (n % 4 + 1)), 1);
        req = 4'b1111;
        for (int n = 0; n < 5; n++) begin
            wait_ack("t2_order", n % 4);
            if (n == 4) req = '0;
        end
        wait_idle("t2_idle");

        // req0 held, req3 pulsed: no starvation
        apply_reset("rst3");
        set_data(0, 8'h5A);
        set_data(3, 8'hC3);
        push(0, 8'h5A, 1); push(3, 8'hC3, 1); push(0, 8'h5A, 1); push(3, 8'hC3, 1);
        req = 4'b1001;
        wait_ack("t3_g0", 0);
        wait_ack("t3_g1", 3);
        req[3] = 1'b0;
        wait_ack("t3_g2", 0);
        req[3] = 1'b1;
        wait_ack("t3_g3", 3);
        req = '0;
        wait_idle("t3_idle");

        // reset during shift bit 5 aborts the frame
        apply_reset("rst4");
        set_data(1, 8'h3C);
        set_data(2, 8'hC3);
        push(1, 8'h3C, 0);
        req = 4'b0010;
        wait_ack("t4_first", 1);
        tick(5 * BIT_CYC + 2);
        check("t4_in_shift", 32'(fsm_state), 32'(SHIFT));
        #2 reset = 1'b0;
        req = '0;
        @(negedge clk);
        check_idle("t4_abort");
        tick(2);
        reset = 1'b1;
        push(1, 8'h3C, 1);
        push(2, 8'hC3, 1);
        req = 4'b0110;
        wait_ack("t4_ptr_restart", 1);
        req[1] = 1'b0;
        wait_ack("t4_next", 2);
        req = '0;
        wait_idle("t4_idle");

        // request withdrawn while busy is never granted
        apply_reset("rst5");
        set_data(0, 8'h81);
        set_data(2, 8'h7E);
        push(0, 8'h81, 1);
        req = 4'b0001;
        wait_ack("t5_grant", 0);
        req = '0;
        tick(10);
        req = 4'b0100;
        tick(20);
        req = '0;
        wait_idle("t5_idle");
        tick(30);
        check("t5_still_idle", 32'(busy), 0);
        check("t5_no_ack", ack_q.size(), 0);

        // two queued frames, then LDAC behaviour
        apply_reset("rst6");
        set_data(0, 8'h0F);
        set_data(1, 8'hF0);
        push(0, 8'h0F, 1);
        push(1, 8'hF0, 1);
        req = 4'b0011;
        wait_ack("t6_first", 0);
        req[0] = 1'b0;
        ldac_early = 0;
        busy_at_gap_end = 1'b1;
        for (int k = 1; k <= FRAME_LEN + 1; k++) begin
            @(negedge clk);
            if (dac_ldac !== LDAC_IDLE) ldac_early++;
            if (k == FRAME_LEN) busy_at_gap_end = busy;
        end
        check("t6_no_ldac_between", ldac_early, 0);
        check("t6_gap_to_idle", 32'(busy_at_gap_end), 0);
        check("t6_second_ack", 32'(ack), 32'(4'b0010));
        req = '0;
        ldac_first = -1; ldac_last = -1; busy_fall = -1;
        for (int k = 1; k <= FRAME_LEN + LDAC_CYC + 4; k++) begin
            @(negedge clk);
            if (dac_ldac !== LDAC_IDLE) begin
                if (ldac_first < 0) ldac_first = k;
                ldac_last = k;
            end
            if (!busy && busy_fall < 0) busy_fall = k;
        end
`ifdef DAC_LDAC_SYNC_EN
        check("t6_ldac_first", ldac_first, FRAME_LEN);
        check("t6_ldac_last", ldac_last, FRAME_LEN + LOAD_LOW_CYC - 1);
`else
        check("t6_ldac_const", ldac_first, -1);
`endif
        check("t6_busy_fall", busy_fall, FRAME_LEN + LDAC_CYC);

        // final report
        tick(5);
        check("end_frames_left", exp_q.size(), 0);
        check("end_acks_left", ack_q.size(), 0);
        check("end_ldac_glitch", ldac_bad, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
